// File: rtl/axi_lite_regfile.sv
// AXI4-Lite slave register file: NUM_REGS registers of DATA_WIDTH bits.
// It supports byte strobes and per-register read-only masking. Read-only
// registers return live hardware data, and each register has a one-cycle
// write pulse.
module axi_lite_regfile #(
    parameter int                  ADDR_WIDTH = 32,
    parameter int                  DATA_WIDTH = 32,
    parameter int                  NUM_REGS   = 8,
    parameter logic [NUM_REGS-1:0] RO_MASK    = '0
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic [ADDR_WIDTH-1:0]          aw_addr_i,
    input  logic                           aw_valid_i,
    output logic                           aw_ready_o,
    input  logic [DATA_WIDTH-1:0]          w_data_i,
    input  logic [DATA_WIDTH/8-1:0]        w_strb_i,
    input  logic                           w_valid_i,
    output logic                           w_ready_o,
    output logic [1:0]                     b_resp_o,
    output logic                           b_valid_o,
    input  logic                           b_ready_i,
    input  logic [ADDR_WIDTH-1:0]          ar_addr_i,
    input  logic                           ar_valid_i,
    output logic                           ar_ready_o,
    output logic [DATA_WIDTH-1:0]          r_data_o,
    output logic [1:0]                     r_resp_o,
    output logic                           r_valid_o,
    input  logic                           r_ready_i,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q_o,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] ro_data_i,
    output logic [NUM_REGS-1:0]            wr_pulse_o
);

    localparam int BYTES = DATA_WIDTH / 8;
    localparam int OFF_W = $clog2(BYTES);
    localparam int IDX_W = $clog2(NUM_REGS);

    // One extra bit so the span itself is representable even when the
    // register block fills the whole address space.
    localparam logic [ADDR_WIDTH:0] ADDR_SPAN = (ADDR_WIDTH+1)'(NUM_REGS * BYTES);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [1:0] WR_IDLE    = 2'd0;
    localparam logic [1:0] WR_HAVE_AW = 2'd1;
    localparam logic [1:0] WR_HAVE_W  = 2'd2;
    localparam logic [1:0] WR_RESP    = 2'd3;

    localparam logic [0:0] RD_IDLE = 1'b0;
    localparam logic [0:0] RD_RESP = 1'b1;

    // Address is in range if it falls below the register block span.
    function automatic logic addr_in_range(input logic [ADDR_WIDTH-1:0] addr);
        return ({1'b0, addr} < ADDR_SPAN);
    endfunction

    // Register index; low byte-offset bits are ignored.
    function automatic logic [IDX_W-1:0] reg_index(input logic [ADDR_WIDTH-1:0] addr);
        return addr[OFF_W +: IDX_W];
    endfunction

    // Merge write data into the current value where the byte strobe is set.
    function automatic logic [DATA_WIDTH-1:0] apply_strb(
        input logic [DATA_WIDTH-1:0] cur,
        input logic [DATA_WIDTH-1:0] wdata,
        input logic [BYTES-1:0]      strb
    );
        logic [DATA_WIDTH-1:0] res;
        res = cur;
        for (int b = 0; b < BYTES; b++) begin
            if (strb[b]) begin
                res[8*b +: 8] = wdata[8*b +: 8];
            end
        end
        return res;
    endfunction

    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic                  ready_en_q;

    logic [1:0]            wr_state;
    logic [ADDR_WIDTH-1:0] aw_addr_p0;
    logic [DATA_WIDTH-1:0] w_data_p0;
    logic [BYTES-1:0]      w_strb_p0;

    logic                  aw_hs;
    logic                  w_hs;
    logic                  wr_commit;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [BYTES-1:0]      wr_strb;
    logic [IDX_W-1:0]      wr_idx;
    logic                  wr_in_range;
    logic                  wr_ok;
    logic [1:0]            wr_resp;

    logic [0:0]            rd_state;
    logic                  ar_hs;
    logic [IDX_W-1:0]      ar_idx;
    logic                  ar_in_range;

    // Readies stay low during reset and come up on the first clock after release.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ready_en_q <= 1'b0;
        end else begin
            ready_en_q <= 1'b1;
        end
    end

    // Handshakes and commit decode. A half that arrives in the completing cycle
    // is taken straight from the bus; an earlier half comes from its latch.
    always_comb begin
        aw_ready_o  = ready_en_q && ((wr_state == WR_IDLE) || (wr_state == WR_HAVE_W));
        w_ready_o   = ready_en_q && ((wr_state == WR_IDLE) || (wr_state == WR_HAVE_AW));
        ar_ready_o  = ready_en_q && (rd_state == RD_IDLE);
        b_valid_o   = (wr_state == WR_RESP);
        r_valid_o   = (rd_state == RD_RESP);

        aw_hs       = aw_valid_i && aw_ready_o;
        w_hs        = w_valid_i && w_ready_o;
        ar_hs       = ar_valid_i && ar_ready_o;

        wr_commit   = (aw_hs || (wr_state == WR_HAVE_AW)) && (w_hs || (wr_state == WR_HAVE_W));
        wr_addr     = aw_hs ? aw_addr_i : aw_addr_p0;
        wr_data     = w_hs ? w_data_i : w_data_p0;
        wr_strb     = w_hs ? w_strb_i : w_strb_p0;
        wr_idx      = reg_index(wr_addr);
        wr_in_range = addr_in_range(wr_addr);
        wr_ok       = wr_in_range && !RO_MASK[wr_idx];

        if (!wr_in_range) begin
            wr_resp = RESP_DECERR;
        end else if (RO_MASK[wr_idx]) begin
            wr_resp = RESP_SLVERR;
        end else begin
            wr_resp = RESP_OKAY;
        end

        ar_idx      = reg_index(ar_addr_i);
        ar_in_range = addr_in_range(ar_addr_i);
    end

    // Hold whichever half of the write (address or data/strobe) arrives first.
    always_ff @(posedge clk_i) begin
        if (aw_hs) begin
            aw_addr_p0 <= aw_addr_i;
        end
        if (w_hs) begin
            w_data_p0 <= w_data_i;
            w_strb_p0 <= w_strb_i;
        end
    end

    // Write FSM: collect AW and W in either order, then hold B until accepted.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_state <= WR_IDLE;
            b_resp_o <= RESP_OKAY;
        end else begin
            case (wr_state)
                WR_IDLE: begin
                    if (wr_commit) begin
                        wr_state <= WR_RESP;
                    end else if (aw_hs) begin
                        wr_state <= WR_HAVE_AW;
                    end else if (w_hs) begin
                        wr_state <= WR_HAVE_W;
                    end
                end
                WR_HAVE_AW, WR_HAVE_W: begin
                    if (wr_commit) begin
                        wr_state <= WR_RESP;
                    end
                end
                default: begin
                    if (b_ready_i) begin
                        wr_state <= WR_IDLE;
                    end
                end
            endcase
            if (wr_commit) begin
                b_resp_o <= wr_resp;
            end
        end
    end

    // Register storage and the per-register write pulse (writable, in-range only).
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
            wr_pulse_o <= '0;
        end else begin
            wr_pulse_o <= '0;
            if (wr_commit && wr_ok) begin
                regs_q[wr_idx]     <= apply_strb(regs_q[wr_idx], wr_data, wr_strb);
                wr_pulse_o[wr_idx] <= 1'b1;
            end
        end
    end

    // Read FSM: capture the response at the AR handshake and hold it until taken.
    // The register array is read before any same-edge commit lands, so a
    // colliding read returns the pre-write value.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_state <= RD_IDLE;
            r_data_o <= '0;
            r_resp_o <= RESP_OKAY;
        end else if (rd_state == RD_IDLE) begin
            if (ar_hs) begin
                rd_state <= RD_RESP;
                if (!ar_in_range) begin
                    r_data_o <= '0;
                    r_resp_o <= RESP_DECERR;
                end else if (RO_MASK[ar_idx]) begin
                    r_data_o <= ro_data_i[int'(ar_idx)*DATA_WIDTH +: DATA_WIDTH];
                    r_resp_o <= RESP_OKAY;
                end else begin
                    r_data_o <= regs_q[ar_idx];
                    r_resp_o <= RESP_OKAY;
                end
            end
        end else if (r_ready_i) begin
            rd_state <= RD_IDLE;
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg_out
        assign reg_q_o[g*DATA_WIDTH +: DATA_WIDTH] = regs_q[g];
    end

endmodule

// File: tb/tb_axi_lite_regfile.sv
// Self-checking bench for axi_lite_regfile: directed corner cases, then
// randomized reads and writes, against a behavioural register-map model.
module tb_axi_lite_regfile;

    localparam int            AW = 32;
    localparam int            DW = 32;
    localparam int            NR = 8;
    localparam logic [NR-1:0] RO = 8'h21;

    logic             clk;
    logic             rst_i;
    logic [AW-1:0]    aw_addr_i;
    logic             aw_valid_i;
    logic             aw_ready_o;
    logic [DW-1:0]    w_data_i;
    logic [DW/8-1:0]  w_strb_i;
    logic             w_valid_i;
    logic             w_ready_o;
    logic [1:0]       b_resp_o;
    logic             b_valid_o;
    logic             b_ready_i;
    logic [AW-1:0]    ar_addr_i;
    logic             ar_valid_i;
    logic             ar_ready_o;
    logic [DW-1:0]    r_data_o;
    logic [1:0]       r_resp_o;
    logic             r_valid_o;
    logic             r_ready_i;
    logic [NR*DW-1:0] reg_q_o;
    logic [NR*DW-1:0] ro_data_i;
    logic [NR-1:0]    wr_pulse_o;

    int            n_vec = 0;
    int            n_err = 0;
    logic [DW-1:0] model_regs [NR];
    logic [NR-1:0] ro_mask = RO;

    axi_lite_regfile #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REGS(NR), .RO_MASK(RO)
    ) dut (
        .clk_i(clk), .rst_i(rst_i),
        .aw_addr_i(aw_addr_i), .aw_valid_i(aw_valid_i), .aw_ready_o(aw_ready_o),
        .w_data_i(w_data_i), .w_strb_i(w_strb_i), .w_valid_i(w_valid_i), .w_ready_o(w_ready_o),
        .b_resp_o(b_resp_o), .b_valid_o(b_valid_o), .b_ready_i(b_ready_i),
        .ar_addr_i(ar_addr_i), .ar_valid_i(ar_valid_i), .ar_ready_o(ar_ready_o),
        .r_data_o(r_data_o), .r_resp_o(r_resp_o), .r_valid_o(r_valid_o), .r_ready_i(r_ready_i),
        .reg_q_o(reg_q_o), .ro_data_i(ro_data_i), .wr_pulse_o(wr_pulse_o)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, n_err=%0d", n_err);
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [NR*DW-1:0] model_flat();
        logic [NR*DW-1:0] v;
        for (int k = 0; k < NR; k++) v[k*DW +: DW] = model_regs[k];
        return v;
    endfunction

    task automatic model_clear();
        for (int k = 0; k < NR; k++) model_regs[k] = '0;
    endtask

    task automatic rand_ro();
        for (int k = 0; k < NR; k++) ro_data_i[k*DW +: DW] = $urandom();
    endtask

    function automatic logic [31:0] rand_addr();
        if ($urandom_range(0, 7) == 0) return 32'h0001_0000 | 32'($urandom_range(0, 7) << 2);
        return 32'($urandom_range(0, 39));
    endfunction

    // Register map semantics: byte address / 4 selects the register.
    task automatic model_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                               output logic [1:0] resp, output logic [NR-1:0] pulse);
        int idx;
        pulse = '0;
        if (addr >= NR*4) begin
            resp = 2'b11;
        end else begin
            idx = int'(addr) / 4;
            if (ro_mask[idx]) begin
                resp = 2'b10;
            end else begin
                resp = 2'b00;
                pulse[idx] = 1'b1;
                for (int b = 0; b < 4; b++)
                    if (strb[b]) model_regs[idx][8*b +: 8] = data[8*b +: 8];
            end
        end
    endtask

    task automatic model_read(input logic [31:0] addr, input logic [NR*DW-1:0] ro,
                              output logic [31:0] data, output logic [1:0] resp);
        int idx;
        if (addr >= NR*4) begin
            data = '0;
            resp = 2'b11;
        end else begin
            idx  = int'(addr) / 4;
            data = ro_mask[idx] ? ro[idx*DW +: DW] : model_regs[idx];
            resp = 2'b00;
        end
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int aw_dly, input int w_dly, input int hold);
        logic [1:0]    exp_resp;
        logic [NR-1:0] exp_pulse;
        bit            aw_done = 0, w_done = 0, aw_fire, w_fire;
        int            cyc = 0;
        @(posedge clk); #1;
        while (!(aw_done && w_done) && cyc < 40) begin
            aw_valid_i = !aw_done && (cyc >= aw_dly);
            aw_addr_i  = aw_valid_i ? addr : $urandom();
            w_valid_i  = !w_done && (cyc >= w_dly);
            w_data_i   = w_valid_i ? data : $urandom();
            w_strb_i   = w_valid_i ? strb : 4'($urandom());
            @(negedge clk);
            aw_fire = aw_valid_i && aw_ready_o;
            w_fire  = w_valid_i && w_ready_o;
            check_eq("b_early", b_valid_o, 1'b0);
            @(posedge clk); #1;
            aw_done |= aw_fire;
            w_done  |= w_fire;
            cyc++;
        end
        aw_valid_i = 0;
        w_valid_i  = 0;
        if (!(aw_done && w_done)) begin
            check_eq("wr_timeout", {aw_done, w_done}, 2'b11);
            return;
        end
        model_write(addr, data, strb, exp_resp, exp_pulse);
        @(negedge clk);
        check_eq("b_valid", b_valid_o, 1'b1);
        check_eq("b_resp", b_resp_o, exp_resp);
        check_eq("wr_pulse", wr_pulse_o, exp_pulse);
        check_eq("reg_q", reg_q_o, model_flat());
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            @(negedge clk);
            check_eq("b_hold_valid", b_valid_o, 1'b1);
            check_eq("b_hold_resp", b_resp_o, exp_resp);
            check_eq("b_hold_rdy", {aw_ready_o, w_ready_o}, 2'b00);
            check_eq("b_hold_pulse", wr_pulse_o, '0);
        end
        b_ready_i = 1;
        @(posedge clk); #1;
        b_ready_i = 0;
        @(negedge clk);
        check_eq("b_done_valid", b_valid_o, 1'b0);
        check_eq("b_done_rdy", {aw_ready_o, w_ready_o}, 2'b11);
    endtask

    task automatic do_read(input logic [31:0] addr, input int hold, output logic [31:0] rdata);
        logic [31:0] exp_d;
        logic [1:0]  exp_r;
        bit          done = 0;
        int          cyc = 0;
        rdata = '0;
        @(posedge clk); #1;
        while (!done && cyc < 40) begin
            ar_valid_i = 1;
            ar_addr_i  = addr;
            @(negedge clk);
            if (ar_ready_o) begin
                done = 1;
                model_read(addr, ro_data_i, exp_d, exp_r);
            end
            @(posedge clk); #1;
            rand_ro();
            cyc++;
        end
        ar_valid_i = 0;
        ar_addr_i  = $urandom();
        if (!done) begin
            check_eq("rd_timeout", done, 1'b1);
            return;
        end
        @(negedge clk);
        rdata = r_data_o;
        check_eq("r_valid", r_valid_o, 1'b1);
        check_eq("r_data", r_data_o, exp_d);
        check_eq("r_resp", r_resp_o, exp_r);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            rand_ro();
            @(negedge clk);
            check_eq("r_hold_valid", r_valid_o, 1'b1);
            check_eq("r_hold_data", r_data_o, exp_d);
            check_eq("r_hold_resp", r_resp_o, exp_r);
            check_eq("r_hold_rdy", ar_ready_o, 1'b0);
        end
        r_ready_i = 1;
        @(posedge clk); #1;
        r_ready_i = 0;
        @(negedge clk);
        check_eq("r_done_valid", r_valid_o, 1'b0);
        check_eq("r_done_rdy", ar_ready_o, 1'b1);
    endtask

    initial begin
        logic [31:0]   rd;
        logic [31:0]   old_val;
        logic [31:0]   wd;
        logic [1:0]    exp_resp;
        logic [NR-1:0] exp_pulse;

        clk = 0; rst_i = 1;
        aw_addr_i = '0; aw_valid_i = 0; w_data_i = '0; w_strb_i = '0; w_valid_i = 0;
        b_ready_i = 0; ar_addr_i = '0; ar_valid_i = 0; r_ready_i = 0;
        rand_ro();
        model_clear();

        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_rdy", {aw_ready_o, w_ready_o, ar_ready_o}, 3'b000);
        check_eq("rst_valid", {b_valid_o, r_valid_o}, 2'b00);
        check_eq("rst_resp", {b_resp_o, r_resp_o}, 4'b0000);
        check_eq("rst_rdata", r_data_o, '0);
        check_eq("rst_regs", reg_q_o, '0);
        check_eq("rst_pulse", wr_pulse_o, '0);
        @(posedge clk); #1;
        rst_i = 0;
        @(posedge clk); #1;
        @(negedge clk);
        check_eq("rdy_after_rst", {aw_ready_o, w_ready_o, ar_ready_o}, 3'b111);

        // Same-cycle AW/W
        do_write(32'h4, 32'hDEADBEEF, 4'hF, 0, 0, 0);
        check_eq("aw_w_same_reg1", reg_q_o[63:32], 32'hDEADBEEF);
        // W first, AW three cycles later, single byte strobe
        do_write(32'h8, 32'h11223344, 4'hF, 0, 0, 0);
        do_write(32'h8, 32'h0000AB00, 4'h2, 3, 0, 1);
        check_eq("w_first_reg2", reg_q_o[95:64], 32'h1122AB44);
        // AW first
        do_write(32'h18, 32'h0BADCAFE, 4'hF, 0, 2, 0);
        // Read-only register: SLVERR write, live hardware data on read
        do_write(32'h0, 32'hCAFEF00D, 4'hF, 0, 1, 0);
        check_eq("ro_reg0_kept", reg_q_o[31:0], 32'h0);
        ro_data_i[31:0] = 32'h12345678;
        do_read(32'h0, 0, rd);
        check_eq("ro_read_data", rd, 32'h12345678);
        // Out of range
        do_read(32'h20, 0, rd);
        do_write(32'h20, 32'h99999999, 4'hF, 0, 0, 0);
        // Back-pressure held for 5 cycles
        do_write(32'h10, 32'hA5A5_5A5A, 4'hF, 1, 0, 5);
        do_read(32'h10, 5, rd);
        check_eq("bp_read_data", rd, 32'hA5A5_5A5A);
        // Zero strobe: OKAY, pulse, no change
        do_write(32'hC, 32'hFFFF_FFFF, 4'h0, 0, 0, 0);
        // Unaligned address: low bits ignored
        do_write(32'h7, 32'h7777_0001, 4'hF, 0, 0, 0);
        do_read(32'h5, 0, rd);

        // Read and write commit at the same edge on the same register
        do_write(32'hC, 32'h0102_0304, 4'hF, 0, 0, 0);
        @(posedge clk); #1;
        old_val = model_regs[3];
        wd = $urandom();
        aw_valid_i = 1; aw_addr_i = 32'hC;
        w_valid_i = 1; w_data_i = wd; w_strb_i = 4'hF;
        ar_valid_i = 1; ar_addr_i = 32'hC;
        @(negedge clk);
        check_eq("conc_rdy", {aw_ready_o, w_ready_o, ar_ready_o}, 3'b111);
        @(posedge clk); #1;
        aw_valid_i = 0; w_valid_i = 0; ar_valid_i = 0;
        model_write(32'hC, wd, 4'hF, exp_resp, exp_pulse);
        @(negedge clk);
        check_eq("conc_r_valid", r_valid_o, 1'b1);
        check_eq("conc_r_old", r_data_o, old_val);
        check_eq("conc_b_valid", b_valid_o, 1'b1);
        check_eq("conc_pulse", wr_pulse_o, exp_pulse);
        check_eq("conc_reg_q", reg_q_o, model_flat());
        b_ready_i = 1; r_ready_i = 1;
        @(posedge clk); #1;
        b_ready_i = 0; r_ready_i = 0;

        // Randomized traffic
        for (int it = 0; it < 80; it++) begin
            if ($urandom_range(0, 1) == 0) begin
                do_write(rand_addr(), $urandom(),
                         ($urandom_range(0, 5) == 0) ? 4'h0 : 4'($urandom()),
                         $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
            end else begin
                do_read(rand_addr(), $urandom_range(0, 2), rd);
            end
        end

        // Reset with AW accepted (W pending) and an R response pending
        @(posedge clk); #1;
        aw_valid_i = 1; aw_addr_i = 32'h4;
        ar_valid_i = 1; ar_addr_i = 32'h4;
        @(negedge clk);
        check_eq("mid_rdy", {aw_ready_o, ar_ready_o}, 2'b11);
        @(posedge clk); #1;
        aw_valid_i = 0; ar_valid_i = 0;
        @(negedge clk);
        check_eq("mid_r_pending", r_valid_o, 1'b1);
        rst_i = 1;
        #1;
        model_clear();
        check_eq("mid_rst_valid", {b_valid_o, r_valid_o}, 2'b00);
        check_eq("mid_rst_rdy", {aw_ready_o, w_ready_o, ar_ready_o}, 3'b000);
        check_eq("mid_rst_regs", reg_q_o, model_flat());
        check_eq("mid_rst_rdata", r_data_o, '0);
        @(posedge clk); #1;
        rst_i = 0;
        w_valid_i = 1; w_data_i = 32'h5555_AAAA; w_strb_i = 4'hF;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check_eq("w_only_b", b_valid_o, 1'b0);
            check_eq("w_only_pulse", wr_pulse_o, '0);
            check_eq("w_only_regs", reg_q_o, model_flat());
            @(posedge clk); #1;
        end
        w_valid_i = 0;
        rst_i = 1;
        @(posedge clk); #1;
        rst_i = 0;
        @(posedge clk); #1;
        do_write(32'h4, 32'h600D_0001, 4'hF, 0, 0, 0);
        do_read(32'h4, 0, rd);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
